// File: rtl/fir_pkg.sv
// Shared types and helpers for the fir_filter family: FSM states, output-width
// rule and the coefficient-list type used for reset coefficient parameters.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_e;

  localparam int FIR_MAX_TAPS = 64;

  // Unused trailing entries are ignored; entry 0 multiplies the newest sample.
  typedef int fir_coef_arr_t [FIR_MAX_TAPS];

  // Full-precision width of an (N+1)-tap sum of WX x WB products.
  function automatic int fir_width_y(input int wx, input int wb, input int n);
    return wx + wb + n + 1;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with a registered product stage; sum_o is the
// accumulator plus the in-flight product, i.e. the total once en has dropped.
module fir_mac #(
  parameter int WIDTH_X = 4,
  parameter int WIDTH_B = 4,
  parameter int WIDTH_Y = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      en,
  input  logic signed [WIDTH_X-1:0] x,
  input  logic signed [WIDTH_B-1:0] b,
  output logic signed [WIDTH_Y-1:0] sum_o
);

  logic signed [WIDTH_Y-1:0] prod_d, prod_q;
  logic signed [WIDTH_Y-1:0] acc_d, acc_q;

  always_comb begin
    prod_d = '0;
    acc_d  = '0;
    if (!clr) begin
      if (en) prod_d = WIDTH_Y'(x) * WIDTH_Y'(b);
      acc_d = acc_q + prod_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign sum_o = acc_q + prod_q;

endmodule

// File: rtl/fir_filter_mc.sv
// Time-multiplexed multi-channel FIR: one shared MAC, one tap per clock,
// per-channel delay lines, runtime-loadable coefficients, valid/ready streams.
module fir_filter_mc
  import fir_pkg::*;
#(
  parameter int            N        = 3,
  parameter int            WIDTH_X  = 4,
  parameter int            WIDTH_B  = 4,
  parameter int            CHANNELS = 2,
  parameter fir_coef_arr_t B        = '{0: 1, 1: 2, 2: 3, 3: 4, default: 0},
  localparam int           WIDTH_Y  = fir_width_y(WIDTH_X, WIDTH_B, N),
  localparam int           WIDTH_C  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int           WIDTH_A  = (N > 0) ? $clog2(N + 1) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [WIDTH_X-1:0] s_data,
  input  logic        [WIDTH_C-1:0] s_chan,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [WIDTH_Y-1:0] m_data,
  output logic        [WIDTH_C-1:0] m_chan,
  input  logic                      coef_we,
  input  logic        [WIDTH_A-1:0] coef_addr,
  input  logic signed [WIDTH_B-1:0] coef_data
);

  // Counter runs to N+1: the extra step drains the MAC's product register.
  localparam int WIDTH_K = $clog2(N + 2);

  fir_state_e                state_d, state_q;
  logic        [WIDTH_K-1:0] k_d, k_q;
  logic        [WIDTH_C-1:0] chan_d, chan_q;
  logic signed [WIDTH_Y-1:0] m_data_d, m_data_q;
  logic        [WIDTH_C-1:0] m_chan_d, m_chan_q;
  logic signed [WIDTH_X-1:0] z_d [CHANNELS][N+1];
  logic signed [WIDTH_X-1:0] z_q [CHANNELS][N+1];
  logic signed [WIDTH_B-1:0] coef_d [N+1];
  logic signed [WIDTH_B-1:0] coef_q [N+1];

  logic                      chan_ok;
  logic        [WIDTH_A-1:0] tap;
  logic                      mac_clr, mac_en;
  logic signed [WIDTH_Y-1:0] mac_sum;

  assign chan_ok = (32'(s_chan) < CHANNELS);
  assign tap     = (k_q <= WIDTH_K'(N)) ? k_q[WIDTH_A-1:0] : '0;

  fir_mac #(
    .WIDTH_X (WIDTH_X),
    .WIDTH_B (WIDTH_B),
    .WIDTH_Y (WIDTH_Y)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr   (mac_clr),
    .en    (mac_en),
    .x     (z_q[chan_q][tap]),
    .b     (coef_q[tap]),
    .sum_o (mac_sum)
  );

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    chan_d   = chan_q;
    m_data_d = m_data_q;
    m_chan_d = m_chan_q;
    z_d      = z_q;
    coef_d   = coef_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (coef_we && (32'(coef_addr) <= N)) coef_d[coef_addr] = coef_data;
        // Out-of-range channels complete the handshake and are dropped.
        if (s_valid && chan_ok) begin
          for (int k = 1; k <= N; k++) z_d[s_chan][k] = z_q[s_chan][k-1];
          z_d[s_chan][0] = s_data;
          chan_d  = s_chan;
          k_d     = '0;
          mac_clr = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        if (k_q == WIDTH_K'(N + 1)) begin
          m_data_d = mac_sum;
          m_chan_d = chan_q;
          state_d  = OUT;
        end else begin
          mac_en = 1'b1;
          k_d    = k_q + 1'b1;
        end
      end
      OUT: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      chan_q   <= '0;
      m_data_q <= '0;
      m_chan_q <= '0;
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k <= N; k++) z_q[c][k] <= '0;
      for (int k = 0; k <= N; k++) coef_q[k] <= WIDTH_B'(B[k]);
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      chan_q   <= chan_d;
      m_data_q <= m_data_d;
      m_chan_q <= m_chan_d;
      z_q      <= z_d;
      coef_q   <= coef_d;
    end
  end

  assign s_ready = (state_q == IDLE) && !rst;
  assign m_valid = (state_q == OUT);
  assign m_data  = m_data_q;
  assign m_chan  = m_chan_q;

endmodule

// File: tb/tb_fir_filter_mc.sv
// Bench for fir_filter_mc: a sample-history model predicts every result and is
// compared each cycle; directed tasks pin latency, stall and reset behaviour.
module tb_fir_filter_mc;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid, s_ready;
  logic signed [3:0] s_data;
  logic              s_chan;
  logic              m_valid, m_ready;
  logic signed [11:0] m_data;
  logic              m_chan;
  logic              coef_we;
  logic        [1:0] coef_addr;
  logic signed [3:0] coef_data;

  int checks = 0;
  int errors = 0;

  fir_filter_mc dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_chan    (s_chan),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_chan    (m_chan),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel's last four samples and the live coefficient set.
  typedef struct { int data; int chan; } res_t;
  res_t exp_q [$];
  int   hist [2][4];
  int   mcoef [4];
  int   bdef [4] = '{1, 2, 3, 4};

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int c = 0; c < 2; c++) for (int k = 0; k < 4; k++) hist[c][k] = 0;
      mcoef = bdef;
    end else begin
      if (m_valid && m_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (coef_we && s_ready) mcoef[coef_addr] = int'(coef_data);
      if (s_valid && s_ready && int'(s_chan) < 2) begin
        res_t r;
        for (int k = 3; k > 0; k--) hist[s_chan][k] = hist[s_chan][k-1];
        hist[s_chan][0] = int'(s_data);
        r.data = 0;
        for (int k = 0; k < 4; k++) r.data += hist[s_chan][k] * mcoef[k];
        r.chan = int'(s_chan);
        exp_q.push_back(r);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (exp_q.size() == 0) chk("unexpected_m_valid", 1, 0);
      else begin
        chk("model_m_data", int'(m_data), exp_q[0].data);
        chk("model_m_chan", int'(m_chan), exp_q[0].chan);
        chk("model_s_ready_in_out", int'(s_ready), 0);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_s_ready", int'(s_ready), 0);
    rst = 1'b0;
    #1;
  endtask

  task automatic send(input int ch, input int d, input bit we = 1'b0,
                      input int addr = 0, input int cd = 0);
    int n = 0;
    while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!s_ready) chk("send_timeout", 0, 1);
    s_valid = 1'b1; s_data = 4'(d); s_chan = 1'(ch);
    coef_we = we; coef_addr = 2'(addr); coef_data = 4'(cd);
    @(posedge clk); #1;
    s_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic wait_out(input int ed, input int ec);
    int n = 0;
    while (!m_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("out_valid", int'(m_valid), 1);
    chk("out_data", int'(m_data), ed);
    chk("out_chan", int'(m_chan), ec);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_chan = 1'b0; m_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_m_valid", int'(m_valid), 0);
    chk("reset_m_data", int'(m_data), 0);
    chk("reset_m_chan", int'(m_chan), 0);
    chk("reset_s_ready", int'(s_ready), 0);
    rst = 1'b0; #1;
    chk("idle_s_ready", int'(s_ready), 1);

    // Latency: accepted at edge t, valid after t+5, idle again after t+6.
    send(0, 1);
    repeat (4) @(posedge clk);
    #1 chk("lat_not_yet", int'(m_valid), 0);
    @(posedge clk); #1;
    chk("lat_valid", int'(m_valid), 1);
    chk("lat_data", int'(m_data), 1);
    chk("lat_chan", int'(m_chan), 0);
    @(posedge clk); #1;
    chk("lat_s_ready_back", int'(s_ready), 1);
    chk("lat_m_valid_drop", int'(m_valid), 0);

    // Interleaved channels with independent histories.
    do_reset();
    send(0, 1);  wait_out(1, 0);
    send(0, 2);  wait_out(4, 0);
    send(1, -8); wait_out(-8, 1);
    send(0, 3);  wait_out(10, 0);
    send(0, 4);  wait_out(20, 0);

    // Downstream stall: outputs frozen, no input accepted.
    m_ready = 1'b0;
    send(0, 5);
    begin
      int n = 0;
      while (!m_valid && n < 50) begin @(posedge clk); #1; n++; end
    end
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", int'(m_valid), 1);
      chk("stall_data", int'(m_data), 30);
      chk("stall_s_ready", int'(s_ready), 0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", int'(m_valid), 0);
    chk("stall_release_ready", int'(s_ready), 1);

    // Same-cycle coefficient write applies; a write during MAC is ignored.
    do_reset();
    send(1, 7, 1'b1, 0, -8);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 4'sd1;
    @(posedge clk); #1;
    coef_we = 1'b0;
    wait_out(-56, 1);
    send(1, 1); wait_out(6, 1);

    // Extreme magnitudes stay exact.
    do_reset();
    for (int a = 0; a < 4; a++) begin
      coef_we = 1'b1; coef_addr = 2'(a); coef_data = -4'sd8;
      @(posedge clk); #1;
    end
    coef_we = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(0, -8); wait_out(64 * i, 0);
    end

    // Reset mid-MAC discards the result and restores history and B.
    send(0, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("midrst_no_valid", int'(m_valid), 0);
      @(posedge clk); #1;
    end
    send(0, 1); wait_out(1, 0);

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
      chk("drain_outstanding", exp_q.size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_filter_mc.md
Name: fir_filter_mc

Overview:
Multi-channel, time-multiplexed FIR filter and successor to fir_filter. It shares one signed multiply-accumulate unit across CHANNELS independent delay lines and evaluates one tap per clock. Coefficients are loadable at runtime. Input and output use valid/ready streams, so it can sit between a channel-interleaved sample source and a downstream consumer that may stall.

Parameters:
N, 3, filter order; N+1 taps
WIDTH_X, 4, signed sample width
WIDTH_B, 4, signed coefficient width
CHANNELS, 2, number of independent channels (>=1)
B, {1,2,3,4}, reset coefficient array [N+1]; B[0] multiplies the newest sample
WIDTH_Y (localparam), WIDTH_X+WIDTH_B+N+1, signed output width
WIDTH_C (localparam), max(1,$clog2(CHANNELS)), channel index width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  block can accept a sample
s_data  in  WIDTH_X  signed input sample
s_chan  in  WIDTH_C  channel of s_data
m_valid  out  1  output result valid
m_ready  in  1  downstream accepts result
m_data  out  WIDTH_Y  signed filter output
m_chan  out  WIDTH_C  channel of m_data
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(N+1)  tap index
coef_data  in  WIDTH_B  signed coefficient value

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge) sets:
  - FSM to IDLE.
  - All delay-line entries of all channels to 0.
  - Coefficients to B.
  - m_valid=0, m_data=0, m_chan=0, accumulator=0, tap counter=0.
- s_ready=0 while rst=1. This overrides any in-flight operation, including reset mid-MAC.
- FSM states:
  - IDLE: s_ready=1. When s_valid=1, the sample is accepted:
    - Shift s_data into delay line z[s_chan]: z[c][0]=s_data, z[c][k]=z[c][k-1].
    - Latch the channel, clear the accumulator, set k=0, go to MAC.
  - MAC: s_ready=0. Each cycle: acc += z[c][k]*coef[k], k++. After the k==N term, load m_data=acc_final and m_chan=c, then go to OUT.
  - OUT: m_valid=1 and s_ready=0. m_data/m_chan are held stable until m_ready=1. On handshake, m_valid=0 next cycle and the FSM returns to IDLE.
- Timing:
  - Latency: sample accepted at edge t gives m_valid=1 from edge t+N+2.
  - Throughput with m_ready=1: one sample per N+3 cycles.
- Arithmetic:
  - Full-precision signed arithmetic; the accumulator is WIDTH_Y bits wide.
  - No rounding, saturation or overflow is possible for any input/coefficient combination.
- s_chan >= CHANNELS (non-power-of-2 CHANNELS): the sample is accepted (handshake completes) and discarded. No delay line changes, no output, FSM stays in IDLE.
- Coefficient writes:
  - coef_we is honoured only in IDLE and is ignored in MAC/OUT.
  - If coef_we and an accepted s_valid occur in the same IDLE cycle, the new coefficient applies to that sample's computation.
- Delay lines are not cleared between samples; each channel keeps its own history.

Decomposition:
- Package fir_pkg:
  - State enum {IDLE, MAC, OUT}.
  - Function returning WIDTH_Y from (WIDTH_X, WIDTH_B, N).
  - Coefficient array typedef, shared with fir_filter.
- Sub-module fir_mac:
  - Signed WIDTH_X x WIDTH_B multiplier plus WIDTH_Y accumulator.
  - Inputs: clear and enable.
  - Used once by fir_filter_mc.
- Delay-line storage and FSM stay in the top module.

Test Plan:
1. Reset, then chan0 s_data=1 accepted at edge t -> m_valid rises at t+5, m_data=1, m_chan=0. With m_ready=1, s_ready returns to 1 at t+6.
2. chan0 samples 1,2,3,4 with chan1 sample -8 interleaved after the second -> chan1 m_data=-8; chan0 outputs 1,4,10,20.
3. Hold m_ready=0 for 10 cycles in OUT -> m_valid, m_data, m_chan stable and s_ready=0 throughout. Raise m_ready -> exactly one transfer, then IDLE.
4. After reset, in IDLE write coef_addr=0, coef_data=-8 in the same cycle as chan1 s_data=7 -> m_data=-56. A coef_we pulse during MAC leaves coefficients unchanged.
5. All coefficients set to -8; chan0 s_data=-8 four times -> outputs 64, 128, 192, 256. There is no wrap (WIDTH_Y=12).
6. Assert rst during MAC -> m_valid never rises. Next chan0 s_data=1 -> m_data=1, confirming delay lines and coefficients B are restored.
